// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial arithmetic units.
// Holds the sequencer state encoding and the default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell used as the serial adder's bit slice.
// Ports: p, q, ci in; sum, co out. Purely combinational.
module fulladder (
    input  logic p,
    input  logic q,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = p ^ q ^ ci;
    assign co  = (p & q) | (ci & (p ^ q));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first.
// Ports: clk, rst (sync, active high), start, a, b, cin in;
//        busy, done, sum, cout out (sum/cout registered, held).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] ss_q;
    logic [WIDTH-1:0] sum_q;
    logic             cy_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_q;

    logic             fa_sum;
    logic             fa_co;

    fulladder u_fa (
        .p   (sa_q[0]),
        .q   (sb_q[0]),
        .ci  (cy_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ss_q    <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        cy_q    <= cin;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is deliberately ignored here; no queueing
                    ss_q  <= {fa_sum, ss_q[WIDTH-1:1]};
                    cy_q  <= fa_co;
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // result published only here so it holds through a later RUN
                        sum_q   <= {fa_sum, ss_q[WIDTH-1:1]};
                        cout_q  <= fa_co;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH 8, 2 and 32).
// Directed vector table plus hand-written multi-cycle sequences.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH = 8
    logic       st8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ci8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    // WIDTH = 2
    logic       st2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       ci2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    // WIDTH = 32
    logic        st32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ci32 = 1'b0;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );
    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(st32), .a(a32), .b(b32), .cin(ci32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept on one edge, scramble inputs, then wait for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es,
                        input logic ec, input string name);
        int n;
        a8 = a; b8 = b; ci8 = c; st8 = 1'b1;
        tick();
        st8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~c;
        chk({name, " busy"}, 64'(busy8), 64'd1);
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'd8);
        chk({name, " sum"}, 64'(sum8), 64'(es));
        chk({name, " cout"}, 64'(cout8), 64'(ec));
        chk({name, " busy_at_done"}, 64'(busy8), 64'd0);
    endtask

    initial begin
        int n;
        int dcount;
        logic [32:0] ref33;
        logic [2:0]  ref3;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset sum", 64'(sum8), 64'd0);
        chk("reset cout", 64'(cout8), 64'd0);
        tick();

        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum,
                 vecs[i].cout, $sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d done_pulse", i), 64'(done8), 64'd0);
        end

        // start pulsed during RUN must be lost
        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        tick();
        tick();
        a8 = 8'hAA; b8 = 8'h55; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        chk("ign busy", 64'(busy8), 64'd1);
        n = 3;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        chk("ign latency", 64'(n), 64'd8);
        chk("ign sum", 64'(sum8), 64'h30);
        chk("ign cout", 64'(cout8), 64'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) dcount++;
        end
        chk("ign no second op", 64'(dcount), 64'd0);

        // reset mid-operation aborts without done
        a8 = 8'h0F; b8 = 8'h0F; ci8 = 1'b0; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        st8 = 1'b1;
        tick();
        rst = 1'b0;
        st8 = 1'b0;
        chk("rst busy", 64'(busy8), 64'd0);
        chk("rst done", 64'(done8), 64'd0);
        chk("rst sum", 64'(sum8), 64'd0);
        chk("rst cout", 64'(cout8), 64'd0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8 || busy8) dcount++;
        end
        chk("rst no done", 64'(dcount), 64'd0);
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_rst");

        // back-to-back: start in DONE cycle
        tick();
        run8(8'h40, 8'h41, 1'b0, 8'h81, 1'b0, "b2b_first");
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; st8 = 1'b1;
        tick();
        st8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        chk("b2b busy", 64'(busy8), 64'd1);
        chk("b2b done", 64'(done8), 64'd0);
        dcount = 0;
        n = 0;
        while (!done8 && n < 20) begin
            if (sum8 !== 8'h81 || cout8 !== 1'b0) dcount++;
            tick();
            n++;
        end
        chk("b2b hold", 64'(dcount), 64'd0);
        chk("b2b latency", 64'(n), 64'd8);
        chk("b2b sum", 64'(sum8), 64'h00);
        chk("b2b cout", 64'(cout8), 64'd1);
        tick();

        // WIDTH = 2 sweep
        for (int i = 0; i < 1000; i++) begin
            a2 = 2'($urandom);
            b2 = 2'($urandom);
            ci2 = 1'($urandom);
            ref3 = 3'(a2) + 3'(b2) + 3'(ci2);
            st2 = 1'b1;
            tick();
            st2 = 1'b0;
            a2 = ~a2; b2 = ~b2;
            n = 0;
            while (!done2 && n < 10) begin
                tick();
                n++;
            end
            chk("w2 latency", 64'(n), 64'd2);
            chk("w2 result", 64'({cout2, sum2}), 64'(ref3));
        end

        // WIDTH = 32 sweep
        for (int i = 0; i < 1000; i++) begin
            a32 = $urandom;
            b32 = $urandom;
            ci32 = 1'($urandom);
            ref33 = 33'(a32) + 33'(b32) + 33'(ci32);
            st32 = 1'b1;
            tick();
            st32 = 1'b0;
            a32 = ~a32; b32 = ~b32;
            n = 0;
            while (!done32 && n < 40) begin
                tick();
                n++;
            end
            chk("w32 latency", 64'(n), 64'd32);
            chk("w32 result", 64'({cout32, sum32}), 64'(ref33));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
